// File: rtl/posit_stream_pkg.sv
// rtl/posit_stream_pkg.sv - shared types and constants for the posit8 MAC stream feeder
package posit_stream_pkg;

  typedef enum logic [2:0] {
    LOAD,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  localparam logic [7:0] POSIT_ZERO = 8'h00;
  localparam logic [7:0] POSIT_NAR  = 8'h80;
  localparam logic [7:0] POSIT_ONE  = 8'h40;

  localparam int DEFAULT_DEPTH = 16;

endpackage

// File: rtl/posit_pair_buf.sv
// rtl/posit_pair_buf.sv - operand-pair register array, one write port, one combinational read port
module posit_pair_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [15:0]   wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [15:0]   rd_data_o
);

  // Contents are deliberately not reset; fill/pointers in the parent define validity.
  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/posit_mac_stream_feeder.sv
// rtl/posit_mac_stream_feeder.sv - buffers posit8 operand pairs and streams them into the MAC
module posit_mac_stream_feeder
  import posit_stream_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] fill,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic             mac_ena,
  output logic             mac_clr,
  input  logic [7:0]       mac_res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data
);

  localparam int AW = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       mac_a_q, mac_a_d;
  logic [7:0]       mac_b_q, mac_b_d;
  logic             mac_ena_q, mac_ena_d;
  logic             mac_clr_q, mac_clr_d;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       res_data_q, res_data_d;

  logic             load_hs;
  logic [15:0]      rd_data;

  assign in_ready = (state_q == LOAD) && (fill_q < CNT_W'(DEPTH));
  assign busy     = (state_q != LOAD);
  assign load_hs  = in_valid & in_ready;

  posit_pair_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i     (clk),
    .wr_en_i   (load_hs),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i ({in_a, in_b}),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  // Outputs are registered, so each state computes what the MAC sees in the following cycle.
  // rd_ptr is one bit wider than the address so a full buffer can be told apart from empty.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mac_a_d     = POSIT_ZERO;
    mac_b_d     = POSIT_ZERO;
    mac_ena_d   = 1'b0;
    mac_clr_d   = 1'b0;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    case (state_q)
      LOAD: begin
        rd_ptr_d = '0;
        if (load_hs) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          fill_d   = fill_q + CNT_W'(1);
        end
        if (start) begin
          if ((fill_q != '0) || load_hs) begin
            state_d   = CLEAR;
            mac_clr_d = 1'b1;
          end else begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_data_d  = POSIT_ZERO;
          end
        end
      end
      CLEAR: begin
        state_d              = STREAM;
        mac_ena_d            = 1'b1;
        {mac_a_d, mac_b_d}   = rd_data;
        rd_ptr_d             = rd_ptr_q + CNT_W'(1);
      end
      STREAM: begin
        if (rd_ptr_q == fill_q) begin
          state_d = DRAIN;
        end else begin
          mac_ena_d          = 1'b1;
          {mac_a_d, mac_b_d} = rd_data;
          rd_ptr_d           = rd_ptr_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        state_d     = DONE;
        res_valid_d = 1'b1;
        res_data_d  = mac_res;
      end
      DONE: begin
        if (res_ready) begin
          state_d  = LOAD;
          fill_d   = '0;
          wr_ptr_d = '0;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      fill_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mac_a_q     <= POSIT_ZERO;
      mac_b_q     <= POSIT_ZERO;
      mac_ena_q   <= 1'b0;
      mac_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= POSIT_ZERO;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_ena_q   <= mac_ena_d;
      mac_clr_q   <= mac_clr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign fill      = fill_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_ena   = mac_ena_q;
  assign mac_clr   = mac_clr_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_posit_mac_stream_feeder.sv
// tb/tb_posit_mac_stream_feeder.sv - directed bench for the posit8 MAC stream feeder with a behavioural MAC
module tb_posit_mac_stream_feeder;
  import posit_stream_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       start = 1'b0;
  logic       busy;
  logic [4:0] fill;
  logic [7:0] mac_a, mac_b;
  logic       mac_ena, mac_clr;
  logic [7:0] mac_res;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;

  int errors = 0;
  int checks = 0;

  int clr_cnt, ena_cnt, lat, idle_bad, busy_bad, ord_bad, stable_bad;
  logic [7:0] cap_a[$];
  logic [7:0] cap_b[$];
  logic [7:0] va[17];
  logic [7:0] vb[17];

  always #5 clk = ~clk;

  posit_mac_stream_feeder #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .start     (start),
    .busy      (busy),
    .fill      (fill),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_ena   (mac_ena),
    .mac_clr   (mac_clr),
    .mac_res   (mac_res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  // posit8, es=0 decode to real (NaR handled by the caller)
  function automatic real dec(input logic [7:0] p);
    logic [7:0] u;
    int run, nf;
    real v;
    if (p == 8'h00) return 0.0;
    u = p[7] ? (~p + 8'd1) : p;
    run = 0;
    for (int j = 6; j >= 0; j--) if (u[j] == u[6] && run == 6 - j) run++;
    nf = (run >= 6) ? 0 : 6 - run;
    v = 1.0 + real'(int'(u) % (1 << nf)) / real'(1 << nf);
    if (u[6]) for (int j = 0; j < run - 1; j++) v = v * 2.0;
    else      for (int j = 0; j < run; j++) v = v / 2.0;
    return p[7] ? -v : v;
  endfunction

  function automatic logic [7:0] enc(input real v);
    logic [7:0] best;
    real bd, d;
    best = 8'h00;
    bd = (v < 0.0) ? -v : v;
    for (int c = 1; c < 256; c++) begin
      if (c != 128) begin
        d = dec(8'(c)) - v;
        if (d < 0.0) d = -d;
        if (d < bd) begin
          bd = d;
          best = 8'(c);
        end
      end
    end
    return best;
  endfunction

  // Behavioural MAC: exact accumulation, registered result, sticky NaR
  real  acc = 0.0;
  logic acc_nar = 1'b0;
  always @(posedge clk) begin
    if (mac_clr) begin
      acc     <= 0.0;
      acc_nar <= 1'b0;
    end else if (mac_ena) begin
      if (mac_a == POSIT_NAR || mac_b == POSIT_NAR) acc_nar <= 1'b1;
      else acc <= acc + dec(mac_a) * dec(mac_b);
    end
  end
  assign mac_res = acc_nar ? POSIT_NAR : enc(acc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_pair(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_batch();
    clr_cnt = 0; ena_cnt = 0; lat = -1; idle_bad = 0; busy_bad = 0;
    cap_a.delete();
    cap_b.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (mac_clr) clr_cnt++;
      if (mac_ena) begin
        ena_cnt++;
        cap_a.push_back(mac_a);
        cap_b.push_back(mac_b);
      end else if (mac_a != 8'h00 || mac_b != 8'h00) begin
        idle_bad++;
      end
      if (!busy) busy_bad++;
      if (res_valid) begin
        lat = c;
        break;
      end
      step();
    end
  endtask

  task automatic accept_result(input string tag);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, "_res_valid_cleared"}, 32'(res_valid), 32'd0);
    check({tag, "_fill_cleared"}, 32'(fill), 32'd0);
    check({tag, "_back_to_load"}, 32'({busy, in_ready}), 32'b01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    va = '{8'h40, 8'h60, 8'h20, 8'h50, 8'hC0, 8'h40, 8'h20, 8'hE0,
           8'h40, 8'h60, 8'hC0, 8'h40, 8'hA0, 8'h20, 8'h40, 8'h40, 8'h7F};
    vb = '{8'h40, 8'h20, 8'h20, 8'h40, 8'h40, 8'h60, 8'h40, 8'h40,
           8'h20, 8'h60, 8'h20, 8'h50, 8'h40, 8'hE0, 8'h40, 8'h40, 8'h7F};

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mac_outs", 32'({mac_ena, mac_clr, mac_a, mac_b}), 32'd0);
    check("rst_res", 32'({res_valid, res_data}), 32'd0);

    // three times 1.0*1.0 -> 3.0
    for (int i = 0; i < 3; i++) load_pair(POSIT_ONE, POSIT_ONE);
    check("t1_fill", 32'(fill), 32'd3);
    run_batch();
    check("t1_clr_cycles", 32'(clr_cnt), 32'd1);
    check("t1_ena_cycles", 32'(ena_cnt), 32'd3);
    check("t1_latency", 32'(lat), 32'd6);
    check("t1_res_data", 32'(res_data), 32'h68);
    check("t1_idle_zero", 32'(idle_bad), 32'd0);
    accept_result("t1");

    // 2.0*0.5 + -1.0*1.0 -> 0
    load_pair(8'h60, 8'h20);
    load_pair(8'hC0, 8'h40);
    run_batch();
    check("t2_latency", 32'(lat), 32'd5);
    check("t2_res_data", 32'(res_data), 32'h00);
    check("t2_busy_held", 32'(busy_bad), 32'd0);
    check("t2_busy_done", 32'(busy), 32'd1);
    accept_result("t2");

    // empty batch
    run_batch();
    check("t3_latency", 32'(lat), 32'd1);
    check("t3_res_data", 32'(res_data), 32'h00);
    check("t3_no_clr_ena", 32'({clr_cnt[15:0], ena_cnt[15:0]}), 32'd0);
    accept_result("t3");

    // 17 offers into a 16-deep buffer; sum of products is 10.0 -> 0x79
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_a = va[i];
      in_b = vb[i];
      if (i == 15) check("t4_ready_at_15", 32'(in_ready), 32'd1);
      if (i == 16) check("t4_ready_at_16", 32'(in_ready), 32'd0);
      step();
    end
    in_valid = 1'b0;
    check("t4_fill_full", 32'(fill), 32'd16);
    run_batch();
    check("t4_ena_cycles", 32'(ena_cnt), 32'd16);
    ord_bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (i >= cap_a.size() || cap_a[i] !== va[i] || cap_b[i] !== vb[i]) ord_bad++;
    end
    check("t4_stream_order", 32'(ord_bad), 32'd0);
    check("t4_latency", 32'(lat), 32'd19);
    check("t4_res_data", 32'(res_data), 32'h79);

    // back-pressure on the result port, start pulses ignored
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      step();
      if (res_valid !== 1'b1 || res_data !== 8'h79 || in_ready !== 1'b0 || busy !== 1'b1) stable_bad++;
    end
    start = 1'b0;
    check("t5_hold_stable", 32'(stable_bad), 32'd0);
    accept_result("t5");

    // reset during the second STREAM cycle
    for (int i = 0; i < 3; i++) load_pair(POSIT_ONE, POSIT_ONE);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("t6_streaming", 32'(mac_ena), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_after_rst", 32'({mac_ena, busy, res_valid}), 32'd0);
    check("t6_fill_after_rst", 32'(fill), 32'd0);
    load_pair(POSIT_ONE, 8'h60);
    run_batch();
    check("t6_latency", 32'(lat), 32'd4);
    check("t6_res_data", 32'(res_data), 32'h60);
    accept_result("t6");

    // NaR operand propagates straight through
    load_pair(POSIT_NAR, POSIT_ONE);
    load_pair(POSIT_ONE, POSIT_ONE);
    run_batch();
    check("t7_nar_res", 32'(res_data), 32'h80);
    accept_result("t7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
